if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Produces the instruction/PC pair, with a valid flag, that the IF/ID pipeline register latches.
- Owns the fetch PC and the ready/valid request/response interface to instruction memory.
- Buffers responses so a downstream stall never loses an instruction; handles branch/jump redirect flushes.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- BUF_DEPTH, 2, response-buffer entries; also the maximum in-flight plus buffered requests (power of two, ≥2).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid (in order, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- stall  in  1  ID cannot take an instruction this cycle
- redirect  in  1  branch/jump taken, flush fetch
- redirect_pc  in  32  new fetch address
- IR_out  out  32  instruction to IF/ID
- PC_out  out  32  PC of IR_out
- inst_valid  out  1  IR_out/PC_out hold a real instruction

Behaviour:
- Reset (asynchronous, active-high): the reset values below are applied at assertion, and all counters are held at 0.
  - fetch_pc=RESET_PC, imem_req_valid=0, inst_valid=0, IR_out=0, PC_out=0, drop_cnt=0, outstanding=0, buffer empty.
  - First request is issued in the first cycle after reset deasserts.
- Issue: imem_req_valid = !rst_q && !redirect && (outstanding + buf_count < BUF_DEPTH); imem_req_addr=fetch_pc.
- Acceptance: on imem_req_valid && imem_req_ready, fetch_pc += 4 (32-bit wrap, no flag) and outstanding++.
- Response: on imem_rsp_valid, outstanding--.
  - If drop_cnt≠0, the response is discarded and drop_cnt--.
  - Otherwise {pc_tag, imem_rsp_data} is pushed into the buffer. pc_tag comes from a PC shadow FIFO of issued addresses.
  - The credit rule guarantees the buffer never overflows. A push when full is an assertion failure.
- Output: inst_valid = buffer non-empty; IR_out/PC_out = head entry (combinational from the buffer).
  - pop = inst_valid && !stall && !redirect.
  - Push and pop in the same cycle are both performed.
  - Push into an empty buffer becomes visible the next cycle (one-cycle buffer latency).
- Redirect cycle:
  - No request is issued and no pop occurs.
  - At the clock edge: buffer flushed, fetch_pc=redirect_pc, drop_cnt = outstanding after this cycle's accept/response accounting.
  - A response arriving in the redirect cycle is discarded.
  - The next cycle issues redirect_pc. ID clears its register on redirect, so the head shown in the redirect cycle is don't-care.
- Redirect while drop_cnt≠0: drop_cnt is reloaded with the current outstanding count, which already covers the earlier drops.
- stall with a full buffer: issue stops through the credit rule; the head stays stable until pop.
- redirect and stall together: redirect wins.
- redirect_pc[1:0]≠0: bits are forced to 00 unless FETCH_ADDR_CHECK_EN is defined.

Optional Feature:
- FETCH_ADDR_CHECK_EN defined:
  - Adds output fetch_adel (1 bit, reset 0). It is set in the cycle after a redirect with redirect_pc[1:0]≠0.
  - No request is issued while it is set. fetch_adel remains set until the next redirect with an aligned target, or reset.
  - PC_out shows the misaligned address and inst_valid=0.
- Undefined: port absent; low bits are masked to 00.

Decomposition:
- Shared package if_pkg:
  - RESET_PC default, INSTR_W=32, ADDR_W=32.
  - fetch_entry_t struct {pc, instr}.
  - NOP_INSTR=32'h0 constant.
- One sub-module fetch_buf: synchronous FIFO of fetch_entry_t with depth BUF_DEPTH, flush input, push/pop/full/empty/count.
- The PC shadow FIFO is a second instance of fetch_buf.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory → addresses 0x3000, 0x3004, 0x3008 on consecutive cycles; inst_valid rises 2 cycles after reset release with PC_out=0x3000.
- stall held 5 cycles mid-stream → at most BUF_DEPTH requests beyond the head; head PC frozen; after release, PCs continue 0x3004, 0x3008 with no gap or duplicate.
- redirect to 0x3100 with 2 requests outstanding → both late responses dropped; next inst_valid shows PC_out=0x3100 with its correct IR.
- Back-to-back redirects 0x3100 then 0x3200 while responses are in flight → only 0x3200-stream instructions ever appear.
- imem_req_ready low 4 cycles → imem_req_addr stable at 0x3008 with fetch_pc not advancing; then resumes.
- With FETCH_ADDR_CHECK_EN, redirect to 0x3102 → fetch_adel=1 next cycle, no requests, inst_valid=0; redirect 0x3200 clears it.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, reset address and the fetch-buffer entry type for the instruction-fetch stage.
package if_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits of a fetch address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_buf.sv
// Small synchronous FIFO (power-of-two depth) with flush; used for the response buffer and the PC shadow.
// fetch_buf_chk flags any push into a full FIFO.
module fetch_buf
  import if_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags, head view and guarded handshakes.
  always_comb begin
    full      = (count_r == (PTR_W+1)'(DEPTH));
    empty     = (count_r == {(PTR_W+1){1'b0}});
    count     = count_r;
    head      = mem_r[rd_ptr_r];
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
  end

  // Ring pointers, occupancy and storage; flush empties without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  fetch_buf_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .full (full)
  );

endmodule

// Overflow monitor: upstream credit accounting must never push into a full FIFO.
module fetch_buf_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  // Push-while-full detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full)) else $error("fetch_buf: push while full");
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, imem request/response handshake, response buffering, redirect flush.
// Optional macro FETCH_ADDR_CHECK_EN: misaligned redirect targets raise fetch_adel instead of being masked.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] IR_out,
  output logic [ADDR_W-1:0]  PC_out,
`ifdef FETCH_ADDR_CHECK_EN
  output logic               fetch_adel,
`endif
  output logic               inst_valid
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic               rst_q_r;
  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [CNT_W-1:0]   drop_cnt_r;
  logic               adel_s;
  logic [ADDR_W-1:0]  redirect_tgt_s;
  logic               accept_s;
  logic               rsp_s;
  logic               push_s;
  logic               pop_s;
  fetch_entry_t       push_entry_s;
  fetch_entry_t       buf_head_s;
  logic [CNT_W-1:0]   buf_count_s;
  logic               buf_full_s;
  logic               buf_empty_s;
  logic [ADDR_W-1:0]  shd_head_s;
  logic [CNT_W-1:0]   shd_count_s;
  logic               shd_full_s;
  logic               shd_empty_s;

`ifdef FETCH_ADDR_CHECK_EN
  logic adel_r;

  // Sticky misaligned-target flag, re-evaluated on every redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adel_r <= 1'b0;
    end else if (redirect) begin
      adel_r <= |redirect_pc[1:0];
    end else begin
      adel_r <= adel_r;
    end
  end

  // Misaligned targets are kept as-is so PC_out can report them.
  always_comb begin
    adel_s         = adel_r;
    fetch_adel     = adel_r;
    redirect_tgt_s = redirect_pc;
  end
`else
  // Without address checking the offset bits are simply dropped.
  always_comb begin
    adel_s         = 1'b0;
    redirect_tgt_s = word_align(redirect_pc);
  end
`endif

  // The shadow FIFO occupancy is the outstanding-request count; issue only while a buffer slot is guaranteed.
  always_comb begin
    imem_req_valid = !rst_q_r && !redirect && !adel_s && !buf_full_s && !shd_full_s &&
                     (({1'b0, shd_count_s} + {1'b0, buf_count_s}) < (CNT_W+1)'(BUF_DEPTH));
    imem_req_addr  = fetch_pc_r;
    accept_s       = imem_req_valid && imem_req_ready;
    rsp_s          = imem_rsp_valid && !shd_empty_s;
    push_s         = rsp_s && !redirect && (drop_cnt_r == {CNT_W{1'b0}});
    push_entry_s   = '{pc: shd_head_s, instr: imem_rsp_data};
    inst_valid     = !buf_empty_s && !adel_s;
    pop_s          = inst_valid && !stall && !redirect;
    if (adel_s) begin
      IR_out = NOP_INSTR;
      PC_out = fetch_pc_r;
    end else begin
      IR_out = buf_head_s.instr;
      PC_out = buf_head_s.pc;
    end
  end

  // Fetch PC, reset qualifier and the number of stale responses still to discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q_r    <= 1'b1;
      fetch_pc_r <= RESET_PC;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      rst_q_r <= 1'b0;
      if (redirect) begin
        fetch_pc_r <= redirect_tgt_s;
        // No accept can happen in a redirect cycle, so only this cycle's response is netted out.
        drop_cnt_r <= shd_count_s - CNT_W'(rsp_s);
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (rsp_s && (drop_cnt_r != {CNT_W{1'b0}})) begin
          drop_cnt_r <= drop_cnt_r - CNT_W'(1'b1);
        end
      end
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .T     (fetch_entry_t)
  ) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (buf_head_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s),
    .count     (buf_count_s)
  );

  // Addresses of issued requests, popped in order as responses return (dropped or kept).
  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .T     (logic [ADDR_W-1:0])
  ) u_pc_shadow (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept_s),
    .push_data (fetch_pc_r),
    .pop       (rsp_s),
    .head      (shd_head_s),
    .full      (shd_full_s),
    .empty     (shd_empty_s),
    .count     (shd_count_s)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: in-order random-latency memory, instruction-stream reference model.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] IR_out;
  logic [31:0] PC_out;
  logic        inst_valid;
`ifdef FETCH_ADDR_CHECK_EN
  logic        fetch_adel;
`endif

  if_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .IR_out         (IR_out),
    .PC_out         (PC_out),
`ifdef FETCH_ADDR_CHECK_EN
    .fetch_adel     (fetch_adel),
`endif
    .inst_valid     (inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          buf_cnt = 0;
  int          lat_min = 0;
  int          lat_extra = 0;
  int          n_acc = 0;
  int          n_pops = 0;
  int          first_req_cyc = -1;
  int          first_iv_cyc = -1;
  logic [31:0] first_addrs [3];
  logic [31:0] exp_fetch;
  logic [31:0] exp_pc;
  bit          adel_m = 1'b0;
  logic [31:0] adel_pc;
  bit          seen_after = 1'b0;
  logic [31:0] first_pc_after;
  logic        s_req_valid;
  logic [31:0] s_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One pipeline cycle: drive at negedge, check shortly after, then advance the reference model.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    req_t        r;
    logic        acc;
    logic        rspv;
    logic        pop_m;
    logic [31:0] tgt;
    @(negedge clk);
    stall          = st;
    redirect       = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    rspv           = (pend.size() != 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rspv;
    if (rspv) imem_rsp_data = mem_word(pend[0].addr);
    else      imem_rsp_data = $urandom;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    check1("req_valid", imem_req_valid, !rd && !adel_m && ((pend.size() + buf_cnt) < DEPTH));
    if (imem_req_valid) check32("req_addr", imem_req_addr, exp_fetch);
    check1("inst_valid", inst_valid, !adel_m && (buf_cnt != 0));
    if (inst_valid && !rd) begin
      check32("pc_out", PC_out, exp_pc);
      check32("ir_out", IR_out, mem_word(exp_pc));
    end
`ifdef FETCH_ADDR_CHECK_EN
    check1("fetch_adel", fetch_adel, adel_m);
    if (adel_m) check32("adel_pc_out", PC_out, adel_pc);
`endif
    acc = imem_req_valid && rdy;
    if (acc) begin
      if (n_acc < 3) first_addrs[n_acc] = imem_req_addr;
      n_acc++;
    end
    if (imem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
    if (inst_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
    if (inst_valid && !st && !rd) n_pops++;
    if (rd) seen_after = 1'b0;
    else if (inst_valid && !seen_after) begin
      seen_after     = 1'b1;
      first_pc_after = PC_out;
    end
    pop_m = !rd && !adel_m && (buf_cnt != 0) && !st;
    if (pop_m) begin
      buf_cnt--;
      exp_pc += 32'd4;
    end
    if (rspv) begin
      r = pend.pop_front();
      if (!rd && !r.stale) buf_cnt++;
    end
    if (acc) begin
      pend.push_back('{addr: imem_req_addr,
                       due: cyc + 1 + lat_min + int'($urandom_range(lat_extra, 0)),
                       stale: 1'b0});
      exp_fetch += 32'd4;
    end
    if (rd) begin
`ifdef FETCH_ADDR_CHECK_EN
      tgt    = rpc;
      adel_m = (rpc[1:0] != 2'b00);
`else
      tgt    = rpc & ~32'd3;
`endif
      adel_pc = rpc;
      foreach (pend[i]) pend[i].stale = 1'b1;
      buf_cnt   = 0;
      exp_fetch = tgt;
      exp_pc    = tgt;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int          n_before;
    logic [31:0] hold_addr;
    logic [31:0] rpc;

    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    exp_fetch = RST_PC; exp_pc = RST_PC; hold_addr = 32'd0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_inst_valid", inst_valid, 1'b0);
    check32("rst_ir_out", IR_out, 32'd0);
    check32("rst_pc_out", PC_out, 32'd0);
`ifdef FETCH_ADDR_CHECK_EN
    check1("rst_fetch_adel", fetch_adel, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Startup with a one-cycle memory.
    lat_min = 0; lat_extra = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, $urandom, 1'b1);
    check1("first_req_cycle0", first_req_cyc == 0, 1'b1);
    check1("first_valid_cycle2", first_iv_cyc == 2, 1'b1);
    for (int i = 0; i < 3; i++) check32("startup_addr", first_addrs[i], RST_PC + 32'(4 * i));

    // Five-cycle stall mid-stream.
    lat_extra = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, $urandom, 1'b1);
    n_before = n_acc;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom, 1'b1);
    check1("stall_issue_bound", (n_acc - n_before) <= DEPTH, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, $urandom, 1'b1);

    // Redirect with two requests in flight.
    lat_min = 2; lat_extra = 0;
    for (int i = 0; i < 40 && pend.size() != 2; i++) step(1'b0, 1'b0, $urandom, 1'b1);
    check1("two_outstanding", pend.size() == 2, 1'b1);
    step(1'b0, 1'b1, 32'h0000_3100, 1'b1);
    for (int i = 0; i < 30 && !seen_after; i++) step(1'b0, 1'b0, $urandom, 1'b1);
    check1("redir_seen", seen_after, 1'b1);
    check32("redir_first_pc", first_pc_after, 32'h0000_3100);

    // Back-to-back redirects with responses in flight.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, $urandom, 1'b1);
    step(1'b0, 1'b1, 32'h0000_3100, 1'b1);
    step(1'b1, 1'b1, 32'h0000_3200, 1'b1);
    for (int i = 0; i < 30 && !seen_after; i++) step(1'b0, 1'b0, $urandom, 1'b1);
    check1("b2b_seen", seen_after, 1'b1);
    check32("b2b_first_pc", first_pc_after, 32'h0000_3200);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, $urandom, 1'b1);

    // Memory not ready for four cycles.
    lat_min = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, $urandom, 1'b0);
      if (i == 0) hold_addr = s_req_addr;
      else        check32("ready_low_addr", s_req_addr, hold_addr);
    end
    check1("ready_low_valid", s_req_valid, 1'b1);
    step(1'b0, 1'b0, $urandom, 1'b1);
    check32("resume_addr", s_req_addr, hold_addr);

`ifdef FETCH_ADDR_CHECK_EN
    // Misaligned redirect target, then recovery.
    step(1'b0, 1'b1, 32'h0000_3102, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, $urandom, 1'b1);
      check1("adel_no_req", s_req_valid, 1'b0);
    end
    step(1'b0, 1'b1, 32'h0000_3200, 1'b1);
    for (int i = 0; i < 30 && !seen_after; i++) step(1'b0, 1'b0, $urandom, 1'b1);
    check1("adel_clear_seen", seen_after, 1'b1);
    check32("adel_clear_pc", first_pc_after, 32'h0000_3200);
`endif

    // Random traffic: stalls, backpressure, variable latency, occasional redirects.
    lat_min = 0; lat_extra = 3;
    for (int i = 0; i < 400; i++) begin
      rpc = 32'h0000_4000 + 32'($urandom_range(1023, 0));
`ifdef FETCH_ADDR_CHECK_EN
      rpc = rpc & ~32'd3;
`endif
      step(($urandom % 4) == 0, ($urandom % 25) == 0, rpc, ($urandom % 3) != 0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, $urandom, 1'b1);
    check1("stream_progress", n_pops > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
